// File: rtl/irq_controller.sv
// irq_controller: maskable-interrupt front end for the s1c88 core.
// Edge-detects 16 sources into pending flags, applies per-source enables and
// per-group priorities, and presents a single registered request (level +
// vector) to the CPU. The presented vector is frozen while iack is high.
module irq_controller #(
   parameter int          NUM_SOURCES = 16,
   parameter logic [7:0]  VECTOR_BASE = 8'h03
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_SOURCES-1:0] irq_src,
   input  logic [2:0]             bus_addr,
   input  logic [7:0]             bus_data_in,
   input  logic                   bus_write,
   input  logic                   bus_read,
   output logic [7:0]             bus_data_out,
   input  logic [1:0]             cpu_mask,
   input  logic                   iack,
   output logic                   irq_request,
   output logic [1:0]             irq_level,
   output logic [7:0]             irq_vector
);

   // Register offsets within the controller window
   localparam logic [2:0] ADDR_PRIO    = 3'd0;
   localparam logic [2:0] ADDR_EN_LO   = 3'd1;
   localparam logic [2:0] ADDR_EN_HI   = 3'd2;
   localparam logic [2:0] ADDR_FLAG_LO = 3'd3;
   localparam logic [2:0] ADDR_FLAG_HI = 3'd4;
   localparam logic [2:0] ADDR_STATUS  = 3'd5;

   logic [NUM_SOURCES-1:0] src_prev_q, src_prev_d;
   logic [NUM_SOURCES-1:0] flag_q, flag_d;
   logic [NUM_SOURCES-1:0] en_q, en_d;
   logic [7:0]             prio_q, prio_d;
   logic [7:0]             bus_data_out_q, bus_data_out_d;
   logic                   irq_request_q, irq_request_d;
   logic [1:0]             irq_level_q, irq_level_d;
   logic [7:0]             irq_vector_q, irq_vector_d;

   logic [NUM_SOURCES-1:0] rise;
   logic [NUM_SOURCES-1:0] w1c;
   logic                   sel_found;
   logic [1:0]             sel_prio;
   logic [3:0]             sel_index;
   logic [7:0]             rd_mux;

   // Register-file writes and edge detection; a new rising edge beats a
   // simultaneous write-1-to-clear so no interrupt is ever lost.
   always_comb begin
      prio_d     = prio_q;
      en_d       = en_q;
      w1c        = '0;
      rise       = irq_src & ~src_prev_q;
      src_prev_d = irq_src;
      if (bus_write) begin
         case (bus_addr)
            ADDR_PRIO:    prio_d     = bus_data_in;
            ADDR_EN_LO:   en_d[7:0]  = bus_data_in;
            ADDR_EN_HI:   en_d[15:8] = bus_data_in;
            ADDR_FLAG_LO: w1c[7:0]   = bus_data_in;
            ADDR_FLAG_HI: w1c[15:8]  = bus_data_in;
            default:      ;
         endcase
      end
      flag_d = (flag_q & ~w1c) | rise;
   end

   // Winner selection: highest group priority above the CPU mask, ties go to
   // the lowest source index because only a strictly higher priority replaces it.
   always_comb begin
      sel_found = 1'b0;
      sel_prio  = 2'd0;
      sel_index = 4'd0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (flag_q[i] && en_q[i] && (prio_q[2*(i/4) +: 2] > cpu_mask)
             && (!sel_found || (prio_q[2*(i/4) +: 2] > sel_prio))) begin
            sel_found = 1'b1;
            sel_prio  = prio_q[2*(i/4) +: 2];
            sel_index = 4'(i);
         end
      end
   end

   // Request outputs: frozen with the request dropped during iack, otherwise
   // level and vector only move when there is a candidate to present.
   always_comb begin
      irq_request_d = 1'b0;
      irq_level_d   = irq_level_q;
      irq_vector_d  = irq_vector_q;
      if (!iack) begin
         irq_request_d = sel_found;
         if (sel_found) begin
            irq_level_d  = sel_prio;
            irq_vector_d = VECTOR_BASE + {4'd0, sel_index};
         end
      end
   end

   // Read mux uses pre-write register values so a same-cycle write is invisible.
   always_comb begin
      rd_mux = 8'h00;
      case (bus_addr)
         ADDR_PRIO:    rd_mux = prio_q;
         ADDR_EN_LO:   rd_mux = en_q[7:0];
         ADDR_EN_HI:   rd_mux = en_q[15:8];
         ADDR_FLAG_LO: rd_mux = flag_q[7:0];
         ADDR_FLAG_HI: rd_mux = flag_q[15:8];
         ADDR_STATUS:  rd_mux = {5'b00000, irq_level_q, irq_request_q};
         default:      rd_mux = 8'h00;
      endcase
      bus_data_out_d = bus_read ? rd_mux : bus_data_out_q;
   end

   // State registers; src_prev resets high so sources already asserted
   // when reset releases do not register as edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         src_prev_q     <= '1;
         flag_q         <= '0;
         en_q           <= '0;
         prio_q         <= 8'h00;
         bus_data_out_q <= 8'h00;
         irq_request_q  <= 1'b0;
         irq_level_q    <= 2'd0;
         irq_vector_q   <= 8'h00;
      end else begin
         src_prev_q     <= src_prev_d;
         flag_q         <= flag_d;
         en_q           <= en_d;
         prio_q         <= prio_d;
         bus_data_out_q <= bus_data_out_d;
         irq_request_q  <= irq_request_d;
         irq_level_q    <= irq_level_d;
         irq_vector_q   <= irq_vector_d;
      end
   end

   assign bus_data_out = bus_data_out_q;
   assign irq_request  = irq_request_q;
   assign irq_level    = irq_level_q;
   assign irq_vector   = irq_vector_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scoreboard bench for irq_controller.
// Stimulus pushes expected read data / request state into queues; a monitor
// process pops and compares whenever the DUT presents the matching output.
module tb_irq_controller;

   typedef struct {
      string      name;
      logic [7:0] data;
   } rd_item_t;

   typedef struct {
      string      name;
      logic       req;
      logic [1:0] lvl;
      logic [7:0] vec;
   } irq_item_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] irq_src = 16'h0000;
   logic [2:0]  bus_addr = 3'd0;
   logic [7:0]  bus_data_in = 8'h00;
   logic        bus_write = 1'b0;
   logic        bus_read = 1'b0;
   logic [7:0]  bus_data_out;
   logic [1:0]  cpu_mask = 2'd0;
   logic        iack = 1'b0;
   logic        irq_request;
   logic [1:0]  irq_level;
   logic [7:0]  irq_vector;

   logic        rd_seen = 1'b0;
   logic        irq_chk = 1'b0;

   rd_item_t    rd_q[$];
   irq_item_t   irq_q[$];
   int          vectors_applied = 0;
   int          miscompares = 0;

   irq_controller #(.NUM_SOURCES(16), .VECTOR_BASE(8'h03)) dut (
      .clk          (clk),
      .reset        (reset),
      .irq_src      (irq_src),
      .bus_addr     (bus_addr),
      .bus_data_in  (bus_data_in),
      .bus_write    (bus_write),
      .bus_read     (bus_read),
      .bus_data_out (bus_data_out),
      .cpu_mask     (cpu_mask),
      .iack         (iack),
      .irq_request  (irq_request),
      .irq_level    (irq_level),
      .irq_vector   (irq_vector)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Remember that a read was issued so its data is checked after the edge
   always @(posedge clk) rd_seen <= bus_read;

   // Monitor: pops expectations and compares presented outputs at the falling edge
   always @(negedge clk) begin
      rd_item_t  r;
      irq_item_t q;
      if (rd_seen) begin
         vectors_applied++;
         if (rd_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_read got=%02h expected=<none>", bus_data_out);
         end else begin
            r = rd_q.pop_front();
            if (bus_data_out !== r.data) begin
               miscompares++;
               $display("[TB] FAIL %s got=%02h expected=%02h", r.name, bus_data_out, r.data);
            end
         end
      end
      if (irq_chk) begin
         vectors_applied++;
         if (irq_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_irq_check got req=%0b lvl=%0d vec=%02h", irq_request, irq_level, irq_vector);
         end else begin
            q = irq_q.pop_front();
            if (irq_request !== q.req || irq_level !== q.lvl || irq_vector !== q.vec) begin
               miscompares++;
               $display("[TB] FAIL %s got req=%0b lvl=%0d vec=%02h expected req=%0b lvl=%0d vec=%02h",
                        q.name, irq_request, irq_level, irq_vector, q.req, q.lvl, q.vec);
            end
         end
      end
   end

   // Hard time limit so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive sources, mask and iack, then let the given number of edges pass
   task automatic applyStimulus(input logic [15:0] src, input logic [1:0] mask,
                                input logic ack, input int cycles);
      irq_src  = src;
      cpu_mask = mask;
      iack     = ack;
      for (int c = 0; c < cycles; c++) tick();
   endtask

   // Queue the expected request state and have the monitor compare it now
   task automatic checkOutput(input string name, input logic req,
                              input logic [1:0] lvl, input logic [7:0] vec);
      irq_item_t it;
      it.name = name;
      it.req  = req;
      it.lvl  = lvl;
      it.vec  = vec;
      irq_q.push_back(it);
      irq_chk = 1'b1;
      @(negedge clk);
      #1;
      irq_chk = 1'b0;
   endtask

   task automatic writeReg(input logic [2:0] addr, input logic [7:0] data);
      bus_addr    = addr;
      bus_data_in = data;
      bus_write   = 1'b1;
      tick();
      bus_write   = 1'b0;
   endtask

   task automatic readReg(input logic [2:0] addr, input logic [7:0] exp, input string name);
      rd_item_t it;
      it.name = name;
      it.data = exp;
      rd_q.push_back(it);
      bus_addr = addr;
      bus_read = 1'b1;
      tick();
      bus_read = 1'b0;
   endtask

   // Directed sequence with hand-computed expectations
   initial begin
      rd_item_t it;

      // Source 5 held high through reset must not fire
      irq_src = 16'h0020;
      tick();
      tick();
      reset = 1'b0;
      checkOutput("reset_outputs", 1'b0, 2'd0, 8'h00);
      applyStimulus(16'h0020, 2'd0, 1'b0, 2);
      readReg(3'd3, 8'h00, "held_src_no_flag");
      checkOutput("held_src_no_req", 1'b0, 2'd0, 8'h00);
      readReg(3'd0, 8'h00, "prio_reset");
      applyStimulus(16'h0000, 2'd0, 1'b0, 1);

      // Single source: flag at t+1, request at t+2
      writeReg(3'd0, 8'h02);
      writeReg(3'd1, 8'h01);
      applyStimulus(16'h0001, 2'd0, 1'b0, 1);
      irq_src = 16'h0000;
      checkOutput("src0_t1_no_req", 1'b0, 2'd0, 8'h00);
      readReg(3'd3, 8'h01, "src0_flag_t1");
      checkOutput("src0_t2_req", 1'b1, 2'd2, 8'h03);
      writeReg(3'd3, 8'h01);
      applyStimulus(16'h0000, 2'd0, 1'b0, 1);
      checkOutput("src0_cleared_hold", 1'b0, 2'd2, 8'h03);

      // Priority arbitration across groups
      writeReg(3'd0, 8'h4B);
      writeReg(3'd1, 8'hFF);
      writeReg(3'd2, 8'hFF);
      applyStimulus(16'h1052, 2'd0, 1'b0, 2);
      checkOutput("arb_src1", 1'b1, 2'd3, 8'h04);
      writeReg(3'd3, 8'h02);
      applyStimulus(16'h1052, 2'd0, 1'b0, 1);
      checkOutput("arb_src4_tie", 1'b1, 2'd2, 8'h07);
      readReg(3'd3, 8'h50, "flag_lo_4_6");
      writeReg(3'd3, 8'h50);
      applyStimulus(16'h1052, 2'd0, 1'b0, 1);
      checkOutput("arb_src12", 1'b1, 2'd1, 8'h0F);
      readReg(3'd4, 8'h10, "flag_hi_12");

      // CPU mask against a lone level-2 source
      writeReg(3'd4, 8'h10);
      applyStimulus(16'h0000, 2'd2, 1'b0, 1);
      applyStimulus(16'h0010, 2'd2, 1'b0, 2);
      checkOutput("mask2_blocks", 1'b0, 2'd1, 8'h0F);
      applyStimulus(16'h0010, 2'd1, 1'b0, 1);
      checkOutput("mask1_passes", 1'b1, 2'd2, 8'h07);
      applyStimulus(16'h0010, 2'd3, 1'b0, 1);
      checkOutput("mask3_blocks", 1'b0, 2'd2, 8'h07);
      applyStimulus(16'h0010, 2'd1, 1'b0, 1);
      checkOutput("mask1_again", 1'b1, 2'd2, 8'h07);

      // iack freeze while a higher-priority source arrives
      applyStimulus(16'h0012, 2'd1, 1'b1, 1);
      checkOutput("iack_cycle1", 1'b0, 2'd2, 8'h07);
      applyStimulus(16'h0012, 2'd1, 1'b1, 1);
      checkOutput("iack_cycle2", 1'b0, 2'd2, 8'h07);
      applyStimulus(16'h0012, 2'd1, 1'b1, 1);
      checkOutput("iack_cycle3", 1'b0, 2'd2, 8'h07);
      applyStimulus(16'h0012, 2'd1, 1'b0, 1);
      checkOutput("after_iack_src1", 1'b1, 2'd3, 8'h04);
      readReg(3'd3, 8'h12, "flags_survive_iack");

      // Set beats W1C on the same bit; unused offsets; status
      irq_src     = 16'h0212;
      bus_addr    = 3'd4;
      bus_data_in = 8'h02;
      bus_write   = 1'b1;
      tick();
      bus_write   = 1'b0;
      readReg(3'd4, 8'h02, "set_beats_w1c");
      readReg(3'd5, 8'h07, "status_req_lvl3");
      readReg(3'd6, 8'h00, "offset6_zero");
      writeReg(3'd7, 8'hFF);
      readReg(3'd7, 8'h00, "offset7_zero");
      writeReg(3'd4, 8'h02);
      readReg(3'd4, 8'h00, "w1c_clears");

      // Read and write in the same cycle returns the old value
      it.name = "read_during_write";
      it.data = 8'hFF;
      rd_q.push_back(it);
      bus_addr    = 3'd1;
      bus_data_in = 8'h0F;
      bus_read    = 1'b1;
      bus_write   = 1'b1;
      tick();
      bus_read    = 1'b0;
      bus_write   = 1'b0;
      readReg(3'd1, 8'h0F, "en_lo_new");

      // Reset in the middle of an iack window
      applyStimulus(16'h0212, 2'd1, 1'b1, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      iack  = 1'b0;
      checkOutput("reset_mid_iack", 1'b0, 2'd0, 8'h00);
      applyStimulus(16'h0212, 2'd1, 1'b0, 1);
      readReg(3'd3, 8'h00, "flags_lost_reset");
      readReg(3'd1, 8'h00, "en_reset");
      checkOutput("no_req_after_reset", 1'b0, 2'd0, 8'h00);

      tick();
      tick();
      if (rd_q.size() != 0 || irq_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL leftover_expectations got=%0d expected=0", rd_q.size() + irq_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
